// File: rtl/keccak_padder.sv
// keccak_padder: packs a 64-bit word message stream into 1088-bit rate blocks,
// applies Keccak multi-rate padding and hands blocks to the permutation core.
module keccak_padder #(
  parameter int unsigned DIN_WIDTH  = 1088,
  parameter int unsigned WORD_WIDTH = 64,
  parameter logic [7:0]  PAD_BYTE   = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [3:0]            in_bytes,
  output logic                  in_ready,
  input  logic                  core_ready,
  output logic [DIN_WIDTH-1:0]  blk_data,
  output logic                  blk_valid,
  output logic                  first_block,
  output logic                  last_block
);

  localparam int unsigned LANES      = DIN_WIDTH / WORD_WIDTH;
  localparam int unsigned RATE_BYTES = DIN_WIDTH / 8;
  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
  localparam int unsigned CNT_W      = $clog2(LANES);

  typedef enum logic {FILL, EMIT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 extra_q, extra_d;
  logic                 final_q, final_d;
  logic [DIN_WIDTH-1:0] acc_q, acc_d;
  logic [DIN_WIDTH-1:0] blk_q, blk_d;

  logic [WORD_WIDTH-1:0] word_m;
  logic [DIN_WIDTH-1:0]  acc_w;
  int unsigned           pos;

  // XOR the domain byte at byte position p and 0x80 into the final rate byte;
  // when p is the final byte both land on it (PAD_BYTE ^ 0x80).
  function automatic logic [DIN_WIDTH-1:0] pad_block(input logic [DIN_WIDTH-1:0] blk,
                                                     input int unsigned p);
    logic [DIN_WIDTH-1:0] r;
    r = blk;
    for (int unsigned b = 0; b < RATE_BYTES; b++) begin
      if (b == p) r[b*8 +: 8] = r[b*8 +: 8] ^ PAD_BYTE;
    end
    r[(RATE_BYTES-1)*8 +: 8] = r[(RATE_BYTES-1)*8 +: 8] ^ 8'h80;
    return r;
  endfunction

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      first_q <= 1'b1;
      extra_q <= 1'b0;
      final_q <= 1'b0;
      acc_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      extra_q <= extra_d;
      final_q <= final_d;
      acc_q   <= acc_d;
      blk_q   <= blk_d;
    end
  end

  // Lane packing, padding and FILL/EMIT sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    extra_d = extra_q;
    final_d = final_q;
    acc_d   = acc_q;
    blk_d   = blk_q;
    word_m  = '0;
    acc_w   = acc_q;

    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      if (k < 32'(in_bytes)) word_m[k*8 +: 8] = in_data[k*8 +: 8];
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      if (l == 32'(cnt_q)) acc_w[l*WORD_WIDTH +: WORD_WIDTH] = word_m;
    end
    pos = 32'(cnt_q) * WORD_BYTES + 32'(in_bytes);

    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (in_last) begin
            state_d = EMIT;
            cnt_d   = '0;
            acc_d   = '0;
            if (pos < RATE_BYTES) begin
              blk_d   = pad_block(acc_w, pos);
              final_d = 1'b1;
            end else begin
              // Message ends exactly on a block boundary: padding goes in a
              // separate pad-only block emitted right after this one.
              blk_d   = acc_w;
              extra_d = 1'b1;
            end
          end else if (32'(cnt_q) == LANES - 1) begin
            state_d = EMIT;
            cnt_d   = '0;
            acc_d   = '0;
            blk_d   = acc_w;
          end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_w;
          end
        end
      end
      EMIT: begin
        if (core_ready) begin
          first_d = 1'b0;
          if (final_q) begin
            final_d = 1'b0;
            first_d = 1'b1;
            state_d = FILL;
          end else if (extra_q) begin
            blk_d   = pad_block('0, 0);
            final_d = 1'b1;
            extra_d = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready    = rst_n && (state_q == FILL);
  assign blk_valid   = (state_q == EMIT) && core_ready;
  assign first_block = blk_valid && first_q;
  assign last_block  = blk_valid && final_q;
  assign blk_data    = blk_q;

endmodule

// File: tb/tb_keccak_padder.sv
// tb_keccak_padder: table-driven messages with a block scoreboard for keccak_padder.
module tb_keccak_padder;

  localparam int unsigned RATE = 136;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          in_ready;
  logic          core_ready;
  logic [1087:0] blk_data;
  logic          blk_valid;
  logic          first_block;
  logic          last_block;

  keccak_padder #(.DIN_WIDTH(1088), .WORD_WIDTH(64), .PAD_BYTE(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
    .core_ready(core_ready), .blk_data(blk_data), .blk_valid(blk_valid),
    .first_block(first_block), .last_block(last_block)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1087:0] data;
    logic          first;
    logic          last;
  } blk_t;

  typedef struct {
    int unsigned len;    // message bytes
    int unsigned pat;    // 0 = counting bytes, 1 = 0xA5, 2 = "abc"
    int unsigned stall;  // core_ready low cycles after each strobe
    int unsigned nblk;   // expected strobes
  } vec_t;

  blk_t          exp_q[$];
  logic [7:0]    msg[0:1023];
  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   strobes = 0;
  int unsigned   stall_n = 0;
  logic [1087:0] last_data;
  logic          last_first;
  vec_t          vecs[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1087:0] got, input logic [1087:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      for (int b = 0; b < 136; b++) begin
        if (got[b*8 +: 8] !== exp[b*8 +: 8]) begin
          $display("FAIL %s: byte %0d got %0h expected %0h", name, b, got[b*8 +: 8], exp[b*8 +: 8]);
          break;
        end
      end
    end
  endtask

  // Reference padding: message || PAD_BYTE || 0* || 0x80 over whole rate blocks
  task automatic push_expected(input int unsigned len);
    logic [7:0] pb[0:543];
    int unsigned nb;
    blk_t e;
    nb = len / RATE + 1;
    for (int i = 0; i < 544; i++) pb[i] = 8'h00;
    for (int unsigned i = 0; i < len; i++) pb[i] = msg[i];
    pb[len] = pb[len] ^ 8'h01;
    pb[nb*RATE-1] = pb[nb*RATE-1] ^ 8'h80;
    for (int unsigned b = 0; b < nb; b++) begin
      e.data = '0;
      for (int unsigned k = 0; k < RATE; k++) e.data[k*8 +: 8] = pb[b*RATE + k];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int unsigned g;
    in_data = d; in_bytes = nb; in_last = last; in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 2000) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Unused bytes of a short word carry 0xEE to expose missing masking
  task automatic send_msg(input int unsigned len);
    int unsigned nw, nb;
    logic [63:0] d;
    nw = (len == 0) ? 1 : (len + 7) / 8;
    for (int unsigned w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? len - 8*w : 8;
      for (int unsigned k = 0; k < 8; k++)
        d[k*8 +: 8] = (k < nb) ? msg[8*w + k] : 8'hEE;
      send_word(d, 4'(nb), w == nw - 1);
    end
  endtask

  task automatic drain(input string name);
    int unsigned g;
    g = 0;
    while ((exp_q.size() != 0 || !core_ready) && g < 5000) begin
      g++;
      @(negedge clk);
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_msg(input int unsigned len, input int unsigned pat);
    for (int unsigned i = 0; i < len; i++)
      msg[i] = (pat == 1) ? 8'hA5 : (pat == 2) ? 8'h61 + 8'(i) : 8'(i*7 + 3);
  endtask

  // Output monitor: compare every strobe against the scoreboard head
  initial begin
    blk_t e;
    forever begin
      @(negedge clk);
      if (blk_valid) begin
        strobes++;
        last_data  = blk_data;
        last_first = first_block;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          chk_blk("blk_data", blk_data, e.data);
          chk("first_block", 64'(first_block), 64'(e.first));
          chk("last_block", 64'(last_block), 64'(e.last));
        end
      end
    end
  end

  // Core model: after each accepted block, hold core_ready low for stall_n cycles
  initial begin
    logic [1087:0] snap;
    core_ready = 1'b1;
    snap = '0;
    forever begin
      @(negedge clk);
      if (blk_valid && stall_n > 0) begin
        @(posedge clk); #1 core_ready = 1'b0;
        for (int i = 0; i < int'(stall_n); i++) begin
          @(negedge clk);
          if (i == 30) snap = blk_data;
        end
        if (stall_n >= 40 && exp_q.size() != 0) begin
          chk_blk("stall_blk_stable", blk_data, snap);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1 core_ready = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1087:0] abc;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_first", 64'(first_block), 64'd0);
    chk("rst_last", 64'(last_block), 64'd0);
    chk_blk("rst_blk_data", blk_data, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    vecs[0] = '{len: 0,   pat: 0, stall: 0,  nblk: 1};
    vecs[1] = '{len: 3,   pat: 2, stall: 0,  nblk: 1};
    vecs[2] = '{len: 135, pat: 0, stall: 0,  nblk: 1};
    vecs[3] = '{len: 136, pat: 1, stall: 0,  nblk: 2};
    vecs[4] = '{len: 300, pat: 0, stall: 48, nblk: 3};
    vecs[5] = '{len: 8,   pat: 0, stall: 0,  nblk: 1};
    vecs[6] = '{len: 129, pat: 0, stall: 3,  nblk: 1};
    vecs[7] = '{len: 137, pat: 0, stall: 0,  nblk: 2};
    vecs[8] = '{len: 272, pat: 1, stall: 5,  nblk: 3};

    foreach (vecs[t]) begin
      fill_msg(vecs[t].len, vecs[t].pat);
      stall_n = vecs[t].stall;
      strobes = 0;
      push_expected(vecs[t].len);
      send_msg(vecs[t].len);
      drain("drain");
      chk("strobe_count", 64'(strobes), 64'(vecs[t].nblk));
      if (vecs[t].len == 0) begin
        chk("empty_byte0", 64'(last_data[7:0]), 64'h01);
        chk("empty_byte135", 64'(last_data[1087:1080]), 64'h80);
      end
      if (vecs[t].len == 135)
        chk("len135_byte135", 64'(last_data[1087:1080]), 64'h81);
      @(posedge clk); #1;
    end

    // Reset in mid-message: five words are dropped, then "abc" starts afresh
    stall_n = 0;
    strobes = 0;
    for (int w = 0; w < 5; w++) send_word(64'h1111_2222_3333_4444 + 64'(w), 4'd8, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_blk("midrst_blk_data", blk_data, '0);
    @(posedge clk); #1;
    fill_msg(3, 2);
    push_expected(3);
    send_msg(3);
    drain("midrst_drain");
    abc = '0;
    abc[31:0] = 32'h01636261;
    abc[1087:1080] = 8'h80;
    chk_blk("midrst_abc", last_data, abc);
    chk("midrst_first", 64'(last_first), 64'd1);
    chk("midrst_strobes", 64'(strobes), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
- Upstream feeder for keccak_2stage_ver2: accepts a 64-bit word message stream, packs it into 1088-bit rate blocks and applies multi-rate padding (domain byte, then 0x80 in the final byte).
- Drives the core's in/first_block/last_block. Emits a block only when the core signals it can take one.
- Fixed to Keccak-256/SHA3-256 rate (136 bytes = 17 lanes).

Parameters:
- DIN_WIDTH, 1088, rate width in bits; must equal the core's DIN_WIDTH; 17 lanes of 64 bits.
- WORD_WIDTH, 64, input word width; one lane.
- PAD_BYTE, 8'h01, domain/pad start byte; 8'h01 = Keccak, 8'h06 = SHA3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  64  message word; byte k at bits [8k+7:8k] (little-endian lane).
- in_valid  in  1  in_data/in_last/in_bytes valid.
- in_last  in  1  word is the final word of the message.
- in_bytes  in  4  valid byte count of the word, 1..8. Valid low bytes only. Must be 8 unless in_last. Value 0 is legal only with in_last (empty tail).
- in_ready  out  1  padder accepts a word this cycle; transfer = in_valid & in_ready.
- core_ready  in  1  core idle and able to absorb a block; driven by top level from core status.
- blk_data  out  1088  block to core `in`; word w at bits [64w+63:64w].
- blk_valid  out  1  one-cycle strobe: blk_data is being handed to the core.
- first_block  out  1  high with blk_valid on the first block of a message.
- last_block  out  1  high with blk_valid on the final (padded) block of a message.

Behaviour:
- Reset (rst_n=0 at clk edge): state=FILL, word counter=0, first flag=1, extra flag=0, blk_data=0, blk_valid/first_block/last_block=0. in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Reset mid-message: any partial block and pending emission are discarded; the next accepted word starts a new message.
- States:
  - FILL: in_ready=1. Each transfer writes in_data (masked to in_bytes; unused bytes 0) into lane cnt, then cnt++.
  - FILL → EMIT when lane 16 is written (block full, cnt wraps to 0), or when in_last is accepted.
  - On in_last with total byte position p = 8*cnt + in_bytes (0..136):
    - p<136: byte p ^= PAD_BYTE, byte 135 ^= 8'h80. If p=135 the byte is PAD_BYTE^0x80 (0x81 for Keccak). Mark final.
    - p=136: block is not final; set extra flag.
  - EMIT: in_ready=0; blk_data is held stable. When core_ready=1, blk_valid=1 for exactly that cycle, with first_block=first flag and last_block=final. first flag then clears.
    - If final: first flag re-arms, go to FILL.
    - If extra flag: load pad-only block (byte 0=PAD_BYTE, byte 135=0x80, rest 0), mark final, clear extra, stay in EMIT.
    - Otherwise go to FILL.
  - EMIT with core_ready=0: wait indefinitely; all outputs held.
- Single-block message: first_block and last_block are both high on the same strobe.
- Latency: block strobe no earlier than the cycle after its completing word is accepted. Zero bubble when core_ready is already high.
- blk_data holds the last emitted block until the next EMIT load. The core samples `in` on the blk_valid cycle.
- in_bytes>8, or in_bytes<8 without in_last: undefined (bench must not drive).
- Lanes beyond a short final word are zero before padding is XORed in.

Test Plan:
- Empty message: in_valid, in_last, in_bytes=0 → one strobe, first=last=1; blk_data byte0=0x01, byte135=0x80, all others 0.
- 3-byte message 0x636261 ("abc") → single block; bytes 0..2=61 62 63, byte3=0x01, byte135=0x80, first=last=1.
- 135-byte message (16 full words + 7-byte word) → one block, byte135=0x81, first=last=1.
- 136-byte message (17 full words of 0xA5A5…) → two strobes:
  - first: data block, first=1, last=0;
  - second: pad-only block (0x01 … 0x80), first=0, last=1.
- 300-byte message with core_ready held low 48 cycles between blocks → three strobes (first/—/last); in_ready=0 while waiting; blk_data stable; no word lost.
- Reset asserted after 5 words of a message, then "abc" sent → only the "abc" block is emitted, with first=1; no stale lane data in blk_data.
